// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_if
// Description : Request/response bundle between a processor (master) and the
//               data memory responder (slave).
//               Request channel : req_valid/req_ready handshake carrying
//                                 req_we, req_addr (byte address), req_wdata.
//               Response channel: rsp_valid/rsp_ready handshake carrying
//                                 rsp_rdata and rsp_err.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Single-port word memory answering one load/store request at a
//               time after a fixed number of wait states.
// Ports       : clk    - clock, all state changes on the rising edge
//               reset  - synchronous, active-high reset
//               bus    - slave side of data_mem_responder_if
//                        (request and response handshakes)
// Parameters  : DEPTH       - number of 32-bit words (power of two, 2..1024)
//               WAIT_CYCLES - wait states between acceptance and response
//                             (0..15)
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  wire logic          clk,
    input  wire logic          reset,
    data_mem_responder_if.slave bus
);

    localparam int         AW          = $clog2(DEPTH);
    localparam logic [3:0] C_WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic [31:0]     mem [DEPTH];

    logic            req_fire;
    logic            req_err;
    logic            enter_resp;
    logic            acc_we;
    logic [AW-1:0]   acc_idx;
    logic [31:0]     acc_wdata;
    logic            acc_err;
    logic            mem_wr;

    assign req_fire = bus.req_valid && (state_q == S_IDLE);

    // Misaligned byte address, or any address bit above the word index set.
    assign req_err  = (bus.req_addr[1:0] != 2'b00) ||
                      (bus.req_addr[31:AW+2] != '0);

    // With zero wait states RESP is entered on the acceptance edge itself, so
    // the memory access must use the live request rather than the latches.
    assign acc_we    = (state_q == S_IDLE) ? bus.req_we             : we_q;
    assign acc_idx   = (state_q == S_IDLE) ? bus.req_addr[AW+1:2]   : idx_q;
    assign acc_wdata = (state_q == S_IDLE) ? bus.req_wdata          : wdata_q;
    assign acc_err   = (state_q == S_IDLE) ? req_err                : err_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        rsp_err_d  = rsp_err_q;
        enter_resp = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    we_d    = bus.req_we;
                    idx_d   = bus.req_addr[AW+1:2];
                    wdata_d = bus.req_wdata;
                    err_d   = req_err;
                    if (C_WAIT_LOAD == 4'd0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = C_WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Response payload is fixed on the edge entering RESP and then held.
        if (enter_resp) begin
            rsp_err_d = acc_err;
            rdata_d   = (acc_err || acc_we) ? 32'd0 : mem[acc_idx];
        end
    end

    assign mem_wr = enter_resp && acc_we && !acc_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= 32'd0;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // Storage is never cleared; reset only blocks a write that would land on
    // the same edge, which abandons a store caught in flight.
    always_ff @(posedge clk) begin
        if (mem_wr && !reset) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Self-checking bench for data_mem_responder. Two instances run
//               side by side: index 0 with zero wait states, index 1 with two.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int wait_of [2] = '{0, 2};

    logic        d_valid [2];
    logic        d_we    [2];
    logic        d_rready[2];
    logic [31:0] d_addr  [2];
    logic [31:0] d_wdata [2];
    logic        o_ready [2];
    logic        o_valid [2];
    logic        o_err   [2];
    logic [31:0] o_rdata [2];

    data_mem_responder_if bus0();
    data_mem_responder_if bus2();

    assign bus0.req_valid = d_valid[0];
    assign bus0.req_we    = d_we[0];
    assign bus0.req_addr  = d_addr[0];
    assign bus0.req_wdata = d_wdata[0];
    assign bus0.rsp_ready = d_rready[0];
    assign o_ready[0]     = bus0.req_ready;
    assign o_valid[0]     = bus0.rsp_valid;
    assign o_rdata[0]     = bus0.rsp_rdata;
    assign o_err[0]       = bus0.rsp_err;

    assign bus2.req_valid = d_valid[1];
    assign bus2.req_we    = d_we[1];
    assign bus2.req_addr  = d_addr[1];
    assign bus2.req_wdata = d_wdata[1];
    assign bus2.rsp_ready = d_rready[1];
    assign o_ready[1]     = bus2.req_ready;
    assign o_valid[1]     = bus2.rsp_valid;
    assign o_rdata[1]     = bus2.rsp_rdata;
    assign o_err[1]       = bus2.rsp_err;

    data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference memory: word contents plus a flag telling whether the word
    // has a defined value (written since power-up).
    logic [31:0] mdl_mem   [2][64];
    bit          mdl_known [2][64];

    task automatic model_req(input int s, input bit we, input logic [31:0] addr,
                             input logic [31:0] wd, output logic [31:0] erd,
                             output logic eerr, output bit known);
        int w;
        eerr  = (addr % 4 != 0) || (addr >= 32'd256);
        erd   = 32'd0;
        known = 1'b1;
        if (!eerr) begin
            w = int'(addr / 4);
            if (we) begin
                mdl_mem[s][w]   = wd;
                mdl_known[s][w] = 1'b1;
            end else begin
                erd   = mdl_mem[s][w];
                known = mdl_known[s][w];
            end
        end
    endtask

    task automatic scramble(input int s);
        d_valid[s] = 1'($urandom_range(0, 1));
        d_we[s]    = 1'($urandom_range(0, 1));
        d_addr[s]  = $urandom;
        d_wdata[s] = $urandom;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction. Called in an IDLE cycle (1 ns after an edge).
    // chain: drive the next request (nx_*) already in the handshake cycle and
    // leave it asserted afterwards.
    task automatic txn(input int s, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input int stall, input bit noise,
                       input bit chain, input bit nx_we, input logic [31:0] nx_addr,
                       input logic [31:0] nx_wd,
                       output logic [31:0] rd, output logic er);
        int lat;
        logic [31:0] exp_rd;
        logic exp_er;
        bit known;
        logic [31:0] held;
        model_req(s, we, addr, wd, exp_rd, exp_er, known);
        chk("req_ready_idle", 32'(o_ready[s]), 32'd1);
        d_valid[s] = 1'b1;
        d_we[s]    = we;
        d_addr[s]  = addr;
        d_wdata[s] = wd;
        d_rready[s] = 1'b0;
        step();
        d_valid[s] = 1'b0;
        lat = 1;
        while (o_valid[s] !== 1'b1 && lat <= 20) begin
            chk("req_ready_wait", 32'(o_ready[s]), 32'd0);
            if (noise) scramble(s);
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'(wait_of[s] + 1));
        rd = 'x;
        er = 1'bx;
        if (o_valid[s] === 1'b1) begin
            held = o_rdata[s];
            for (int i = 0; i < stall; i++) begin
                d_rready[s] = 1'b0;
                if (noise) scramble(s);
                chk("req_ready_resp", 32'(o_ready[s]), 32'd0);
                chk("rsp_valid_hold", 32'(o_valid[s]), 32'd1);
                chk("rdata_stable", o_rdata[s], held);
                step();
            end
            rd = o_rdata[s];
            er = o_err[s];
            if (known) chk("rdata_model", rd, exp_rd);
            chk("err_model", 32'(er), 32'(exp_er));
            d_rready[s] = 1'b1;
            if (noise) scramble(s);
            if (chain) begin
                d_valid[s] = 1'b1;
                d_we[s]    = nx_we;
                d_addr[s]  = nx_addr;
                d_wdata[s] = nx_wd;
            end
            step();
            d_rready[s] = 1'b0;
            if (!chain) d_valid[s] = 1'b0;
            chk("rsp_valid_after", 32'(o_valid[s]), 32'd0);
        end
    endtask

    task automatic check_reset_state(input int s);
        chk("rst_req_ready", 32'(o_ready[s]), 32'd1);
        chk("rst_rsp_valid", 32'(o_valid[s]), 32'd0);
        chk("rst_rsp_rdata", o_rdata[s], 32'd0);
        chk("rst_rsp_err",   32'(o_err[s]), 32'd0);
    endtask

    typedef struct {
        int          s;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          stall;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic er;

        tbl[0]  = '{1, 1'b1, 32'h10,       32'hDEADBEEF, 0, 32'h0,        1'b0};
        tbl[1]  = '{1, 1'b0, 32'h10,       32'h0,        0, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1, 1'b0, 32'h13,       32'h0,        0, 32'h0,        1'b1};
        tbl[3]  = '{1, 1'b0, 32'h100,      32'h0,        0, 32'h0,        1'b1};
        tbl[4]  = '{1, 1'b1, 32'h0,        32'h11111111, 0, 32'h0,        1'b0};
        tbl[5]  = '{1, 1'b1, 32'hFC,       32'h22222222, 0, 32'h0,        1'b0};
        tbl[6]  = '{1, 1'b1, 32'h100,      32'h33333333, 0, 32'h0,        1'b1};
        tbl[7]  = '{1, 1'b0, 32'h0,        32'h0,        1, 32'h11111111, 1'b0};
        tbl[8]  = '{1, 1'b0, 32'hFC,       32'h0,        0, 32'h22222222, 1'b0};
        tbl[9]  = '{1, 1'b1, 32'h80000010, 32'h44444444, 0, 32'h0,        1'b1};
        tbl[10] = '{1, 1'b0, 32'h10,       32'h0,        2, 32'hDEADBEEF, 1'b0};
        tbl[11] = '{0, 1'b1, 32'h40,       32'hCAFEF00D, 0, 32'h0,        1'b0};
        tbl[12] = '{0, 1'b0, 32'h40,       32'h0,        5, 32'hCAFEF00D, 1'b0};
        tbl[13] = '{0, 1'b0, 32'h42,       32'h0,        0, 32'h0,        1'b1};

        for (int s = 0; s < 2; s++) begin
            d_valid[s] = 1'b0; d_we[s] = 1'b0; d_rready[s] = 1'b0;
            d_addr[s] = 32'd0; d_wdata[s] = 32'd0;
            for (int w = 0; w < 64; w++) begin
                mdl_mem[s][w] = 32'd0;
                mdl_known[s][w] = 1'b0;
            end
        end
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        check_reset_state(0);
        check_reset_state(1);

        // Directed table
        for (int i = 0; i < 14; i++) begin
            txn(tbl[i].s, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].stall,
                1'b0, 1'b0, 1'b0, 32'd0, 32'd0, rd, er);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
        end

        // Inputs toggling while busy, next request raised in the handshake cycle
        for (int s = 0; s < 2; s++) begin
            txn(s, 1'b1, 32'h30, 32'h12345678, 2, 1'b1, 1'b1, 1'b0, 32'h30, 32'h0, rd, er);
            txn(s, 1'b0, 32'h30, 32'h0, 1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, rd, er);
            chk("chain_load", rd, 32'h12345678);
        end

        // Reset during WAIT abandons a pending store
        txn(1, 1'b1, 32'h20, 32'h5, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, rd, er);
        txn(1, 1'b0, 32'h20, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, rd, er);
        chk("pre_reset_load", rd, 32'h5);
        d_valid[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 32'h20; d_wdata[1] = 32'hA;
        step();
        d_valid[1] = 1'b0;
        step();
        chk("in_wait_busy", 32'(o_ready[1]), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_state(1);
        check_reset_state(0);
        txn(1, 1'b0, 32'h20, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, rd, er);
        chk("abandoned_store", rd, 32'h5);

        // Reset coinciding with a request: request is dropped
        d_valid[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h20;
        reset = 1'b1;
        step();
        reset = 1'b0;
        d_valid[1] = 1'b0;
        check_reset_state(1);
        step();
        chk("no_accept_in_reset", 32'(o_ready[1]), 32'd1);

        // Randomized traffic against the reference model
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 40; n++) begin
                int r;
                logic [31:0] a;
                r = $urandom_range(0, 9);
                a = 32'($urandom_range(0, 63)) << 2;
                if (r == 0) a = a | 32'($urandom_range(1, 3));
                if (r == 1) a = 32'd256 + (32'($urandom_range(0, 1000)) << 2);
                if (r == 2) a = $urandom | 32'h8000_0000;
                txn(s, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2),
                    1'($urandom_range(0, 1)), 1'b0, 1'b0, 32'h0, 32'h0, rd, er);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
